// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding synchronous-memory read feeding a
// 2-entry {instr, pc} skid FIFO towards decode, with redirect-driven flush.
module instr_fetch #(
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    PC_WIDTH      = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rd,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [DATA_WIDTH-1:0]    id_instr,
    output logic [PC_WIDTH-1:0]      id_pc
);

    logic [PC_WIDTH-1:0]   pc;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic                  inflight;
    logic [1:0]            count;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [DATA_WIDTH-1:0] fifo_instr [2];
    logic [PC_WIDTH-1:0]   fifo_pc    [2];

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  fifo_nonempty;
    logic [2:0]            occupancy;
    logic [1:0]            count_next;

    assign imem_addr     = pc[ADDRESS_WIDTH+1:2];
    assign fifo_nonempty = (count != 2'd0);
    assign id_valid      = fifo_nonempty && !redirect_valid;
    assign pop           = id_valid && id_ready;
    assign push          = inflight && !redirect_valid;

    // Slots already claimed (buffered + in flight) less the one leaving this
    // cycle must stay below 2, written without subtraction to avoid underflow.
    assign occupancy  = {1'b0, count} + {2'b00, inflight};
    assign issue      = !redirect_valid && (occupancy < (3'd2 + {2'b00, pop}));
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // Outputs read zero whenever the FIFO is empty, which covers reset since
    // the data storage itself is not reset.
    assign id_instr = fifo_nonempty ? fifo_instr[rd_ptr] : '0;
    assign id_pc    = fifo_nonempty ? fifo_pc[rd_ptr]    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc <= pc + PC_WIDTH'(4);
            end
            count <= count_next;
            if (push) begin
                wr_ptr <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= pc;
        end
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rd;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: synchronous memory model, program-order
// scoreboard of expected PCs, and cycle-exact latency/stall/redirect checks.
module tb_instr_fetch;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int PW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rd;
    logic          redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic          id_valid;
    logic          id_ready;
    logic [DW-1:0] id_instr;
    logic [PW-1:0] id_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;
    logic [PW-1:0] exp_pc_q[$];

    instr_fetch #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PC_WIDTH(PW),
        .RESET_PC('0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_rd(imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_instr(id_instr),
        .id_pc(id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [PW-1:0] byte_pc);
        logic [PW-1:0] w;
        w = (byte_pc >> 2) & PW'(32'h1F);
        return 32'h1000_0000 + w;
    endfunction

    // Synchronous memory: data for the address of cycle k appears in cycle k+1
    always @(posedge clk) imem_rd <= mem_word({25'b0, imem_addr, 2'b00});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic sb_reload(input logic [PW-1:0] target);
        exp_pc_q.delete();
        for (int i = 0; i < 64; i++) exp_pc_q.push_back({target[PW-1:2], 2'b00} + PW'(4 * i));
    endtask

    task automatic sb_check();
        logic [PW-1:0] e;
        if (id_valid && id_ready) begin
            if (exp_pc_q.size() == 0) begin
                chk("sb_unexpected_delivery", id_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_pc_q.pop_front();
                chk("sb_pc", id_pc, e);
                chk("sb_instr", id_instr, mem_word(e));
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        sb_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            half();
            adv();
        end
    endtask

    // Releases reset between edges so the following rising edge is edge 0
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        sb_reload('0);
        cyc_no = 0;
        adv();
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #12;
        enter_reset();

        // Streaming: first instruction in cycle 2, then one per cycle
        release_reset();
        half(); chk("lat_c1_valid", 32'(id_valid), 32'd0); adv();
        half();
        chk("lat_c2_valid", 32'(id_valid), 32'd1);
        chk("lat_c2_pc", id_pc, 32'h0);
        chk("lat_c2_instr", id_instr, 32'h1000_0000);
        adv();
        for (int i = 3; i < 10; i++) begin
            half(); chk("stream_valid", 32'(id_valid), 32'd1); adv();
        end

        // Stall from cycle 0 for 6 cycles
        enter_reset();
        id_ready = 1'b0;
        release_reset();
        for (int i = 1; i < 6; i++) begin
            half();
            if (cyc_no >= 3) begin
                chk("stall_imem_addr", 32'(imem_addr), 32'd2);
                chk("stall_hold_pc", id_pc, 32'h0);
                chk("stall_hold_instr", id_instr, 32'h1000_0000);
            end
            adv();
        end
        id_ready = 1'b1;
        half(); chk("unstall_pc0", id_pc, 32'h0); adv();
        half(); chk("unstall_pc4", id_pc, 32'h4); adv();
        half(); chk("unstall_pc8", id_pc, 32'h8); adv();
        run(3);

        // Redirect in cycle 5 to 0x40
        enter_reset();
        release_reset();
        run(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        sb_reload(32'h40);
        half(); chk("redir_c5_valid", 32'(id_valid), 32'd0); adv();
        redirect_valid = 1'b0;
        half(); chk("redir_c6_valid", 32'(id_valid), 32'd0); adv();
        half(); chk("redir_c7_valid", 32'(id_valid), 32'd0); adv();
        half();
        chk("redir_c8_valid", 32'(id_valid), 32'd1);
        chk("redir_c8_pc", id_pc, 32'h40);
        chk("redir_c8_instr", id_instr, 32'h1000_0010);
        adv();
        run(4);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        sb_reload(32'h40);
        half(); adv();
        redirect_valid = 1'b0;
        run(2);
        half();
        chk("misalign_valid", 32'(id_valid), 32'd1);
        chk("misalign_pc", id_pc, 32'h40);
        adv();
        run(3);

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        sb_reload(32'h20);
        half(); adv();
        redirect_pc = 32'h60;
        sb_reload(32'h60);
        half(); adv();
        redirect_valid = 1'b0;
        half(); chk("b2b_r2_valid", 32'(id_valid), 32'd0); adv();
        half(); chk("b2b_r3_valid", 32'(id_valid), 32'd0); adv();
        half();
        chk("b2b_valid", 32'(id_valid), 32'd1);
        chk("b2b_pc", id_pc, 32'h60);
        chk("b2b_instr", id_instr, 32'h1000_0018);
        adv();
        run(3);

        // Reset pulse with the FIFO full, then restart from RESET_PC
        id_ready = 1'b0;
        run(4);
        chk("prerst_full_valid", 32'(id_valid), 32'd1);
        enter_reset();
        id_ready = 1'b1;
        release_reset();
        half(); chk("rerst_c1_valid", 32'(id_valid), 32'd0); adv();
        half();
        chk("rerst_c2_valid", 32'(id_valid), 32'd1);
        chk("rerst_c2_pc", id_pc, 32'h0);
        adv();
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- ADDRESS_WIDTH, 5, instruction-memory word-address width
- DATA_WIDTH, 32, instruction width
- PC_WIDTH, 32, byte-address PC width
- RESET_PC, 0, byte address fetched first after reset
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- imem_addr, out, ADDRESS_WIDTH, word address to instruction memory
- imem_rd, in, DATA_WIDTH, instruction memory read data, valid one cycle after the address is presented
- redirect_valid, in, 1, branch/jump redirect request
- redirect_pc, in, PC_WIDTH, redirect target byte address
- id_valid, out, 1, instruction available to decode
- id_ready, in, 1, decode accepts the instruction
- id_instr, out, DATA_WIDTH, instruction to decode
- id_pc, out, PC_WIDTH, byte address of id_instr
REQ-003 SHALL use a single clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 SHALL hold a fetch PC register pc with bits [1:0] always 0.
REQ-005 SHALL drive imem_addr = pc[ADDRESS_WIDTH+1:2] combinationally every cycle.
REQ-006 SHALL track one in-flight request (inflight flag plus inflight_pc) and a 2-entry output FIFO of {instr, pc} (count 0..2).
REQ-007 SHALL define pop = id_valid && id_ready.
REQ-008 SHALL issue when !redirect_valid && (count + inflight - pop) < 2.
- On issue: inflight <= 1, inflight_pc <= pc, pc <= pc + 4.
- PC addition SHALL wrap modulo 2^PC_WIDTH.
REQ-009 SHALL, with no issue and no redirect, clear inflight at the clock edge.
REQ-010 SHALL push {imem_rd, inflight_pc} into the FIFO when inflight && !redirect_valid.
REQ-011 SHALL leave count unchanged when a push and a pop occur in the same cycle; the invariant count + inflight <= 2 SHALL hold, so a push into a full FIFO never occurs.
REQ-012 SHALL drive id_valid = (count != 0) && !redirect_valid, with id_instr and id_pc taken from the FIFO head.
REQ-013 SHALL hold id_instr and id_pc stable while id_valid && !id_ready.
REQ-014 SHALL, on redirect_valid, at the clock edge:
- clear the FIFO (count <= 0) and inflight;
- load pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00} (misaligned low bits ignored);
- not consume the head, since id_valid is 0 that cycle.
REQ-015 SHALL, after a redirect in cycle r, issue redirect_pc in cycle r+1 and assert id_valid with it in cycle r+3.
REQ-016 SHALL treat back-to-back redirects so that the last one wins; earlier targets are never delivered.
REQ-017 SHALL sustain 1 instruction/cycle with id_ready held high after the pipeline fills.
REQ-018 SHALL, when stalled (id_ready low), fill the FIFO to 2 and then stop issuing; imem_addr SHALL then hold the next unfetched PC.
REQ-019 SHALL deliver instructions in strict program order, with no duplicates or drops except those flushed by a redirect.

Reset
REQ-020 SHALL, while rst_n is low, force pc = RESET_PC, count = 0, inflight = 0, id_valid = 0; id_instr and id_pc SHALL read 0.
REQ-021 SHALL, on reset assertion mid-operation, immediately discard the in-flight request and FIFO contents.
REQ-022 SHALL, with rst_n released before edge 0, issue RESET_PC in cycle 0 and assert id_valid in cycle 2.

Verification
REQ-023 Reset release, id_ready=1, memory word k = 0x1000_0000+k -> id_valid from cycle 2; id_pc = 0x0, 0x4, 0x8, ... one per cycle; id_instr = 0x1000_0000, 0x1000_0001, ...
REQ-024 id_ready=0 from cycle 0 for 6 cycles, then 1 -> FIFO holds pc 0x0 and 0x4; imem_addr = 2 during the stall; after release 0x0, 0x4, 0x8 delivered in order, none lost.
REQ-025 redirect_valid=1, redirect_pc=0x40 in cycle 5 -> id_valid=0 in cycles 5-7; cycle 8 id_pc=0x40, id_instr=word 16; no older PCs appear after cycle 5.
REQ-026 redirect_pc=0x43 -> next delivered id_pc = 0x40.
REQ-027 Redirects to 0x20 then 0x60 in consecutive cycles -> first delivered id_pc = 0x60.
REQ-028 rst_n pulsed low mid-stream with FIFO full -> id_valid=0 asynchronously; after release, restarts at RESET_PC with 2-cycle latency.
